// File: rtl/pe_pkg.sv
// Shared types and default sizes for the processing-element accumulator.
package pe_pkg;

  localparam int DEFAULT_BITWIDTH = 32;
  localparam int DEFAULT_LENGTH   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_sat_add.sv
// Combinational BITWIDTH-bit unsigned add with carry-out.
// With ACC_SATURATE_EN defined the sum clamps to all-ones on carry-out.
module acc_sat_add #(
  parameter int BITWIDTH = 32
) (
  input  logic [BITWIDTH-1:0] i_a,
  input  logic [BITWIDTH-1:0] i_b,
  output logic [BITWIDTH-1:0] o_sum,
  output logic                o_carry
);

  logic [BITWIDTH:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_full[BITWIDTH];

`ifdef ACC_SATURATE_EN
  // Once clamped, any further non-zero term carries again, so the clamp persists.
  assign o_sum = o_carry ? {BITWIDTH{1'b1}} : w_full[BITWIDTH-1:0];
`else
  assign o_sum = w_full[BITWIDTH-1:0];
`endif

endmodule

// File: rtl/pe_accumulator.sv
// Sums LENGTH unsigned terms per dot product and presents a registered result
// with a sticky overflow flag. Optional clamping via ACC_SATURATE_EN.
//
// Handshakes: a beat transfers on a rising clk edge where valid and ready are
// both 1; valid must hold its data until that edge, and ready is decoded from
// registered state only, never from any input.
module pe_accumulator
  import pe_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH,
  parameter int LENGTH   = DEFAULT_LENGTH
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [BITWIDTH-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [BITWIDTH-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                overflow,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  localparam int CNT_W = $clog2(LENGTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);

  state_t              r_state;
  logic [BITWIDTH-1:0] r_acc;
  logic [BITWIDTH-1:0] r_dout;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf;
  logic                r_overflow;

  logic [BITWIDTH-1:0] w_sum;
  logic                w_carry;
  logic                w_beat;

  acc_sat_add #(.BITWIDTH(BITWIDTH)) u_add (
    .i_a     (r_acc),
    .i_b     (din),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_beat = (r_state == ACCUM) && din_valid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_dout     <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_beat) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_carry;
            r_cnt <= r_cnt + 1'b1;
            // The last beat's result goes straight to the output registers.
            if (r_cnt == LAST_CNT) begin
              r_dout     <= w_sum;
              r_overflow <= r_ovf | w_carry;
              r_state    <= DONE;
            end
          end
        end
        DONE: begin
          if (dout_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign din_ready  = (r_state == ACCUM);
  assign dout_valid = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign dout       = r_dout;
  assign overflow   = r_overflow;
  assign dbg_state  = r_state;

endmodule
